serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
//   Inverse-direction companion to the team's adder cells.
//   Built around a single full-subtractor cell plus a borrow flip-flop.
//   Sits behind a valid/ready operand port and a valid/ready result port for area-cheap datapaths.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range >= 1
// PORTS
//   clk         input   1      single clock, all state updates on rising edge
//   rst_n       input   1      synchronous, active-low reset (sampled on clk rising edge)
//   in_valid    input   1      operands a, b, bin present
//   in_ready    output  1      block can accept operands
//   a           input   WIDTH  minuend
//   b           input   WIDTH  subtrahend
//   bin         input   1      borrow-in (chaining)
//   out_valid   output  1      result present
//   out_ready   input   1      consumer accepts result
//   diff        output  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout        output  1      borrow-out: 1 iff a < b + bin (unsigned)
//   zero        output  1      diff == 0
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, zero=0.
//     Internal shift registers, borrow FF and counter are cleared.
//   States:
//     IDLE  in_ready=1.
//           in_valid&in_ready at edge t: latch a->sa, b->sb, bin->borrow, cnt=0; go RUN.
//     RUN   in_ready=0, out_valid=0. Each edge:
//             d_bit = sa[0]^sb[0]^borrow
//             borrow <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow)
//             sa, sb shift right; d_bit shifted into diff MSB; cnt++
//           At edge t+WIDTH (cnt reaches WIDTH-1 -> final bit): go DONE.
//             diff holds the full result; bout = final borrow; zero = (diff==0).
//     DONE  out_valid=1; diff/bout/zero held stable while out_valid=1 and out_ready=0.
//           out_valid&out_ready at an edge: go IDLE.
//   Timing:
//     Latency: out_valid rises WIDTH cycles after the accepting edge.
//     Throughput: one op per WIDTH+2 cycles minimum (no accept in DONE).
//     Outputs (diff, bout, zero) are registered; no combinational path from inputs to outputs.
//     in_ready is a pure function of state.
//   Boundary conditions:
//     in_valid while busy is ignored; the upstream source holds it.
//     a, b, bin changes after acceptance have no effect.
//     Wrap-around: 0 - 1 gives diff=all-ones, bout=1.
//     WIDTH=1: exactly one RUN cycle.
//     rst_n low in any state aborts the operation immediately; no out_valid is produced for it.
//   diff is an unsigned modulo result. Signed-overflow detection is out of scope.
//   cnt width = $clog2(WIDTH+1).
// STRUCTURE
//   Package serial_sub_pkg:
//     state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2
//     function cnt_w(WIDTH)
//   Sub-module full_subtractor (a, b, bin -> d, bout): combinational, instantiated once.
//   Top level: FSM, counter, operand shift registers, result shift register, borrow FF.
// TESTING
//   WIDTH=8, a=5, b=3, bin=0 -> after 8 cycles out_valid=1, diff=2, bout=0, zero=0.
//   a=3, b=5, bin=0 -> diff=8'hFE, bout=1.
//   a=0, b=0, bin=1 -> diff=8'hFF, bout=1.
//   a=7, b=7 -> diff=0, zero=1, bout=0.
//   out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; accept on out_ready=1, then IDLE.
//   rst_n=0 mid-RUN (cnt=3) -> next cycle IDLE, out_valid=0, diff=0.
//     A new op then completes correctly.
//   WIDTH=1 instance: a=0, b=1 -> diff=1, bout=1, out_valid one cycle after accept.
//   Random 1000 ops with random in_valid/out_ready gaps.
//     Scoreboard checks diff and bout against {bout,diff} = {1'b0,a} - b - bin.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and counter sizing.
package serial_sub_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StRun  = RUN,
        StDone = DONE
    } state_e;

    // Bit counter must be able to hold the value WIDTH.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: o_d = i_a - i_b - i_bin, o_bout set when the bit needs a borrow.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    // Difference bit and borrow-out of a single column.
    always_comb begin
        o_d    = i_a ^ i_b ^ i_bin;
        o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, behind valid/ready operand and result handshakes.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int CntW = cnt_w(WIDTH);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_diff;
    logic [WIDTH-1:0] w_diff_next;
    logic [CntW-1:0]  r_cnt;
    logic             r_borrow;
    logic             r_bout;
    logic             r_zero;
    logic             w_d_bit;
    logic             w_borrow_next;
    logic             w_accept;
    logic             w_last;

    full_subtractor u_full_subtractor (
        .i_a    (r_sa[0]),
        .i_b    (r_sb[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d_bit),
        .o_bout (w_borrow_next)
    );

    // Handshake decode, result-shift value and FSM next state.
    always_comb begin
        w_accept    = (r_state == StIdle) && in_valid;
        w_last      = (r_cnt == CntW'(WIDTH - 1));
        w_diff_next = r_diff >> 1;
        w_diff_next[WIDTH-1] = w_d_bit;
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (in_valid) w_state_next = StRun;
            StRun:   if (w_last) w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register with synchronous reset; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand/result shift registers, borrow flop, bit counter and result flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_sa     <= a;
            r_sb     <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
        end else if (r_state == StRun) begin
            r_sa     <= r_sa >> 1;
            r_sb     <= r_sb >> 1;
            r_borrow <= w_borrow_next;
            r_diff   <= w_diff_next;
            r_cnt    <= r_cnt + CntW'(1);
            // Flags are captured only on the final bit so they stay valid through DONE.
            if (w_last) begin
                r_bout <= w_borrow_next;
                r_zero <= (w_diff_next == '0);
            end
        end
    end

    // Handshake outputs depend on state only; data outputs come straight from flops.
    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
        diff      = r_diff;
        bout      = r_bout;
        zero      = r_zero;
    end

endmodule
